// File: rtl/max7219_serial_tx.sv
// max7219_serial_tx: 3-wire serial driver for a MAX7219 8-digit display.
// After reset it sends the five initialisation frames. After that, each accepted
// update strobe refreshes all eight digit registers from a shadow copy of i_digits.
// Optional build macro MAX7219_REINIT_EN: when it is defined, the five init frames
// are sent again in front of every refresh, so a browned-out display recovers.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_INIT    | shifting the five configuration frames after reset
// ST_IDLE    | nothing to send; waiting for a strobe (or a held pending request)
// ST_REFRESH | shifting the digit frames taken from the shadow register
module max7219_serial_tx #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_update_stb,
  input  logic [63:0] i_digits,
  output logic        o_busy,
  output logic        o_serial_clk,
  output logic        o_serial_dout,
  output logic        o_serial_load
);

  localparam int unsigned     DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);

  // 16 bits x (low + high) phases, then two phases with LOAD high.
  localparam logic [5:0] LAST_PHASE = 6'd33;
  localparam logic [5:0] LOAD_PHASE = 6'd32;

  localparam logic [3:0] LAST_INIT_FRAME = 4'd4;
`ifdef MAX7219_REINIT_EN
  localparam logic [3:0] LAST_REFRESH_FRAME = 4'd12;
`else
  localparam logic [3:0] LAST_REFRESH_FRAME = 4'd7;
`endif

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_REFRESH
  } state_t;

  state_t           state;
  logic [3:0]       frame_idx;
  logic [5:0]       phase;
  logic [DIV_W-1:0] div_cnt;
  logic             pending;
  logic [63:0]      shadow;

  logic [15:0]      cur_word;
  logic [5:0]       nxt_phase;
  logic             nxt_clk;
  logic             nxt_dout;
  logic             nxt_load;

  function automatic logic [15:0] init_word(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'h0C01;               // leave shutdown
      4'd1:    w = 16'h0F00;               // display test off
      4'd2:    w = 16'h0B07;               // scan all eight digits
      4'd3:    w = 16'h0900;               // raw segments, no BCD decode
      default: w = {12'h0A0, INTENSITY};
    endcase
    return w;
  endfunction

  function automatic logic [15:0] digit_word(input logic [2:0] k, input logic [63:0] sh);
    return {4'h0, {1'b0, k} + 4'd1, sh[{k, 3'b000} +: 8]};
  endfunction

  // Select the frame being shifted and the serial pin levels of the next phase.
  always_comb begin
    cur_word = init_word(frame_idx);
    if (state == ST_REFRESH) begin
`ifdef MAX7219_REINIT_EN
      if (frame_idx > LAST_INIT_FRAME) begin
        cur_word = digit_word(3'(frame_idx - 4'd5), shadow);
      end
`else
      cur_word = digit_word(frame_idx[2:0], shadow);
`endif
    end
    nxt_phase = phase + 6'd1;
    nxt_clk   = 1'b0;
    nxt_dout  = 1'b0;
    nxt_load  = 1'b0;
    if (nxt_phase >= LOAD_PHASE) begin
      nxt_load = 1'b1;
    end else begin
      nxt_clk  = nxt_phase[0];
      nxt_dout = cur_word[~nxt_phase[4:1]];
    end
  end

  // Sequencer: phase divider, bit/frame stepping, pending strobe and registered pins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_INIT;
      frame_idx     <= 4'd0;
      phase         <= 6'd0;
      div_cnt       <= DIV_RELOAD;
      pending       <= 1'b0;
      shadow        <= 64'd0;
      o_busy        <= 1'b1;
      o_serial_clk  <= 1'b0;
      o_serial_dout <= 1'b0;
      o_serial_load <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= DIV_RELOAD;
          if (i_en && (i_update_stb || pending)) begin
            // Phase 0 of every frame drives clk=0 and dout=bit15=0, which the
            // pins already hold in idle, so nothing needs re-driving here.
            shadow    <= i_digits;
            pending   <= 1'b0;
            state     <= ST_REFRESH;
            frame_idx <= 4'd0;
            phase     <= 6'd0;
            o_busy    <= 1'b1;
          end
        end
        default: begin
          if (i_en && i_update_stb) begin
            pending <= 1'b1;
          end
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_RELOAD;
            if (phase != LAST_PHASE) begin
              phase         <= nxt_phase;
              o_serial_clk  <= nxt_clk;
              o_serial_dout <= nxt_dout;
              o_serial_load <= nxt_load;
            end else begin
              phase         <= 6'd0;
              o_serial_clk  <= 1'b0;
              o_serial_dout <= 1'b0;
              o_serial_load <= 1'b0;
              if (state == ST_INIT) begin
                if (frame_idx != LAST_INIT_FRAME) begin
                  frame_idx <= frame_idx + 4'd1;
                end else begin
                  frame_idx <= 4'd0;
                  state     <= ST_IDLE;
                  o_busy    <= 1'b0;
                end
              end else begin
                if (frame_idx != LAST_REFRESH_FRAME) begin
                  frame_idx <= frame_idx + 4'd1;
                end else if (pending && i_en) begin
                  // Back-to-back restart; a strobe in this very cycle is covered
                  // by the data latched now, so the request is fully consumed.
                  frame_idx <= 4'd0;
                  shadow    <= i_digits;
                  pending   <= 1'b0;
                end else begin
                  frame_idx <= 4'd0;
                  state     <= ST_IDLE;
                  o_busy    <= 1'b0;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule
